// File: rtl/frame_stream_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : frame_stream_decoder                                    |
// | Function : Pops 17-bit marker-framed words from a FIFO, strips the |
// |            markers and emits a valid/ready RGB565 stream tagged    |
// |            with x/y, sof, sol and frame_done. Bad framing is       |
// |            counted, pulsed and resynchronised.                     |
// | Option   : DECODER_ROW_MARKERS_EN - ROW_START and FRAME_END are    |
// |            required; when undefined rows are delimited by the      |
// |            pixel count only and those markers count as unknown.    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module frame_stream_decoder #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        queue_empty,
  output logic        queue_rd_en,
  input  logic [16:0] queue_data,
  output logic [15:0] pixel_data,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        pixel_sof,
  output logic        pixel_sol,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_done,
  output logic [7:0]  error_count,
  output logic        error_pulse
);

  localparam logic [16:0] c_FRAME_START = 17'h10000;
`ifdef DECODER_ROW_MARKERS_EN
  localparam logic [16:0] c_ROW_START   = 17'h10001;
  localparam logic [16:0] c_FRAME_END   = 17'h1FFFF;
`endif
  localparam logic [10:0] c_LAST_X = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] c_LAST_Y = 11'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_ROW   = 2'd1,
    PIXELS     = 2'd2,
    WAIT_END   = 2'd3
  } state_t;

  state_t      state_q;
  logic        rd_q;          // a word requested last cycle is on queue_data now
  logic [10:0] x_q;           // coordinate the next accepted pixel will carry
  logic [10:0] y_q;
  logic [7:0]  err_cnt_q;
  logic        err_pulse_q;
  // Output beat and its one-entry overflow slot: {data, x, y, sof, sol}
  logic [39:0] out_q;
  logic [39:0] hold_q;
  logic        out_vld_q;
  logic        hold_vld_q;
`ifdef DECODER_ROW_MARKERS_EN
  logic        done_q;
  logic        w_is_rs;
  logic        w_is_fe;
`else
  logic        out_last_q;
  logic        hold_last_q;
`endif

  logic        w_is_pix;
  logic        w_is_fs;
  logic        w_out_free;
  logic        w_emit;
  logic        w_last;
  logic        w_err;
  logic [39:0] w_beat;

  assign w_is_pix   = rd_q && !queue_data[16];
  assign w_is_fs    = rd_q && (queue_data == c_FRAME_START);
`ifdef DECODER_ROW_MARKERS_EN
  assign w_is_rs    = rd_q && (queue_data == c_ROW_START);
  assign w_is_fe    = rd_q && (queue_data == c_FRAME_END);
`endif
  assign w_out_free = !out_vld_q || pixel_ready;
  assign w_emit     = w_is_pix && (state_q == PIXELS);
  assign w_last     = (x_q == c_LAST_X) && (y_q == c_LAST_Y);
  assign w_beat     = {queue_data[15:0], x_q, y_q,
                       (x_q == 11'd0) && (y_q == 11'd0), (x_q == 11'd0)};

  // Only one read outstanding; a parked beat or a stalled output blocks reads.
  assign queue_rd_en = !reset && !queue_empty && !hold_vld_q && w_out_free;

  assign {pixel_data, pixel_x, pixel_y, pixel_sof, pixel_sol} = out_q;
  assign pixel_valid = out_vld_q;
  assign error_count = err_cnt_q;
  assign error_pulse = err_pulse_q;
`ifdef DECODER_ROW_MARKERS_EN
  assign frame_done  = done_q;
`else
  // Frame closes on the handshake of its last pixel.
  assign frame_done  = out_vld_q && pixel_ready && out_last_q;
`endif

  // Classify the arriving word as a framing error for the current state.
  always_comb begin
    w_err = 1'b0;
    if (rd_q) begin
      if (!queue_data[16])  w_err = (state_q != PIXELS);
      else if (w_is_fs)     w_err = (state_q != WAIT_FRAME);
`ifdef DECODER_ROW_MARKERS_EN
      else if (w_is_rs)     w_err = (state_q == PIXELS) || (state_q == WAIT_END);
      else if (w_is_fe)     w_err = (state_q == WAIT_ROW) || (state_q == PIXELS);
`endif
      else                  w_err = 1'b1;
    end
  end

  // Read tracking, framing FSM, coordinate counters and error/done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q        <= 1'b0;
      state_q     <= WAIT_FRAME;
      x_q         <= 11'd0;
      y_q         <= 11'd0;
      err_cnt_q   <= 8'd0;
      err_pulse_q <= 1'b0;
`ifdef DECODER_ROW_MARKERS_EN
      done_q      <= 1'b0;
`endif
    end else begin
      rd_q        <= queue_rd_en;
      err_pulse_q <= w_err;
      if (w_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
`ifdef DECODER_ROW_MARKERS_EN
      done_q      <= w_is_fe && (state_q == WAIT_END);
`endif
      if (w_is_pix) begin
        if (state_q == PIXELS) begin
          if (x_q == c_LAST_X) begin
            x_q <= 11'd0;
            y_q <= y_q + 11'd1;
`ifdef DECODER_ROW_MARKERS_EN
            state_q <= (y_q == c_LAST_Y) ? WAIT_END : WAIT_ROW;
`else
            state_q <= (y_q == c_LAST_Y) ? WAIT_FRAME : PIXELS;
`endif
          end else begin
            x_q <= x_q + 11'd1;
          end
        end else if (state_q == WAIT_ROW) begin
          state_q <= WAIT_FRAME;
        end
      end else if (w_is_fs) begin
        x_q <= 11'd0;
        y_q <= 11'd0;
`ifdef DECODER_ROW_MARKERS_EN
        state_q <= WAIT_ROW;
`else
        state_q <= PIXELS;
`endif
      end
`ifdef DECODER_ROW_MARKERS_EN
      else if (w_is_rs) begin
        if (state_q == WAIT_ROW) begin
          state_q <= PIXELS;
        end else if (state_q == PIXELS) begin
          x_q <= 11'd0;
          y_q <= y_q + 11'd1;
          if (y_q == c_LAST_Y) state_q <= WAIT_FRAME;
        end
      end else if (w_is_fe) begin
        state_q <= WAIT_FRAME;
      end
`endif
    end
  end

  // Output register with a one-entry park slot for beats that arrive during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= 40'd0;
      hold_q      <= 40'd0;
      out_vld_q   <= 1'b0;
      hold_vld_q  <= 1'b0;
`ifndef DECODER_ROW_MARKERS_EN
      out_last_q  <= 1'b0;
      hold_last_q <= 1'b0;
`endif
    end else if (hold_vld_q) begin
      if (w_out_free) begin
        out_q      <= hold_q;
        out_vld_q  <= 1'b1;
        hold_vld_q <= 1'b0;
`ifndef DECODER_ROW_MARKERS_EN
        out_last_q <= hold_last_q;
`endif
      end
    end else if (w_emit) begin
      if (w_out_free) begin
        out_q      <= w_beat;
        out_vld_q  <= 1'b1;
`ifndef DECODER_ROW_MARKERS_EN
        out_last_q <= w_last;
`endif
      end else begin
        hold_q      <= w_beat;
        hold_vld_q  <= 1'b1;
`ifndef DECODER_ROW_MARKERS_EN
        hold_last_q <= w_last;
`endif
      end
    end else if (pixel_ready) begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef DECODER_ROW_MARKERS_EN
  logic w_unused;
  assign w_unused = w_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_frame_stream_decoder                                 |
// | Function : Randomised bench for frame_stream_decoder against a     |
// |            word-stream reference model (10x4 frames).              |
// | Option   : DECODER_ROW_MARKERS_EN selects the marker-mode model.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_frame_stream_decoder;

  localparam int W = 10;
  localparam int H = 4;
  localparam logic [16:0] c_FS = 17'h10000;
  localparam logic [16:0] c_RS = 17'h10001;
  localparam logic [16:0] c_FE = 17'h1FFFF;

  logic        clk;
  logic        reset;
  logic        queue_empty;
  logic        queue_rd_en;
  logic [16:0] queue_data;
  logic [15:0] pixel_data;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        pixel_sof;
  logic        pixel_sol;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        frame_done;
  logic [7:0]  error_count;
  logic        error_pulse;

  frame_stream_decoder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .queue_empty (queue_empty),
    .queue_rd_en (queue_rd_en),
    .queue_data  (queue_data),
    .pixel_data  (pixel_data),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_sof   (pixel_sof),
    .pixel_sol   (pixel_sol),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .frame_done  (frame_done),
    .error_count (error_count),
    .error_pulse (error_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    bit          last;
  } beat_t;

  logic [16:0] fifo[$];
  beat_t       exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int n_err_pulse;
  int n_done;

  // reference model: frame geometry tracked as plain counters
  bit m_in_frame;
  bit m_in_row;
  int m_x, m_y, m_err, m_done;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_in_row = 0; m_x = 0; m_y = 0; m_err = 0; m_done = 0;
    n_err_pulse = 0; n_done = 0;
  endtask

  task automatic model_word(input logic [16:0] w);
    beat_t b;
    if (!w[16]) begin
      if (m_in_row) begin
        b.d = w[15:0]; b.x = m_x; b.y = m_y;
`ifdef DECODER_ROW_MARKERS_EN
        b.last = 0;
`else
        b.last = (m_x == W-1) && (m_y == H-1);
        if (b.last) m_done++;
`endif
        exp_q.push_back(b);
        m_x++;
        if (m_x == W) begin
          m_x = 0; m_y++;
`ifdef DECODER_ROW_MARKERS_EN
          m_in_row = 0;
`else
          m_in_row = (m_y < H);
          m_in_frame = m_in_row;
`endif
        end
      end else begin
        m_err++;
        if (m_in_frame && m_y < H) m_in_frame = 0;
      end
    end else if (w == c_FS) begin
      if (m_in_frame) m_err++;
      m_in_frame = 1; m_x = 0; m_y = 0;
`ifdef DECODER_ROW_MARKERS_EN
      m_in_row = 0;
`else
      m_in_row = 1;
`endif
    end
`ifdef DECODER_ROW_MARKERS_EN
    else if (w == c_RS) begin
      if (m_in_row) begin
        m_err++; m_x = 0; m_y++;
        if (m_y == H) begin m_in_frame = 0; m_in_row = 0; end
      end else if (m_in_frame && m_y < H) begin
        m_in_row = 1;
      end else if (m_in_frame) begin
        m_err++;
      end
    end else if (w == c_FE) begin
      if (m_in_frame && !m_in_row && m_y == H) m_done++;
      else if (m_in_frame) m_err++;
      m_in_frame = 0; m_in_row = 0;
    end
`endif
    else begin
      m_err++;
    end
  endtask

  task automatic push(input logic [16:0] w);
    fifo.push_back(w);
    model_word(w);
  endtask

  task automatic push_pix(input int n);
    for (int i = 0; i < n; i++) push({1'b0, 16'($urandom)});
  endtask

  task automatic push_row_marker();
`ifdef DECODER_ROW_MARKERS_EN
    push(c_RS);
`endif
  endtask

  task automatic push_end_marker();
`ifdef DECODER_ROW_MARKERS_EN
    push(c_FE);
`endif
  endtask

  task automatic push_frame();
    push(c_FS);
    for (int r = 0; r < H; r++) begin
      push_row_marker();
      push_pix(W);
    end
    push_end_marker();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; queue_empty = 1'b0; pixel_ready = 1'b1; queue_data = 17'h1ABCD;
    #1;
    check_val("rst_outs", {queue_rd_en, pixel_data, pixel_x, pixel_y, pixel_sof, pixel_sol,
                           pixel_valid, frame_done, error_count, error_pulse}, 64'd0);
    repeat (2) @(negedge clk);
    queue_empty = 1'b1;
    reset = 1'b0;
    fifo.delete();
    exp_q.delete();
    model_reset();
  endtask

  task automatic run_stream(input int budget, input int ready_pct, input int gap_pct,
                            input bit must_finish, output int used);
    logic [16:0] pend_w;
    logic [39:0] prev_f;
    logic [39:0] cur_f;
    beat_t b;
    bit pend = 0;
    bit prev_stall = 0;
    bit fin = 0;
    int idle = 0;
    used = 0;
    pend_w = '0;
    prev_f = '0;
    while (used < budget && !fin) begin
      @(negedge clk);
      used++;
      queue_data  = pend ? pend_w : 17'($urandom);
      pend        = 0;
      pixel_ready = ($urandom_range(0, 99) < ready_pct);
      queue_empty = (fifo.size() == 0) || ($urandom_range(0, 99) < gap_pct);
      #1;
      cur_f = {pixel_data, pixel_x, pixel_y, pixel_sof, pixel_sol};
      if (prev_stall) begin
        check_val("stall_valid", pixel_valid, 1);
        check_val("stall_hold", cur_f, prev_f);
      end
      if (pixel_valid && !pixel_ready) check_val("rd_while_stalled", queue_rd_en, 0);
      if (queue_rd_en) begin
        check_val("rd_when_empty", queue_empty, 0);
        if (!queue_empty) begin
          pend_w = fifo.pop_front();
          pend = 1;
        end
      end
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 64'(exp_q.size()), 1);
        end else begin
          b = exp_q.pop_front();
          check_val("beat", cur_f, {b.d, 11'(b.x), 11'(b.y), (b.x == 0) && (b.y == 0), b.x == 0});
`ifndef DECODER_ROW_MARKERS_EN
          check_val("done_on_last", frame_done, b.last);
`endif
        end
      end
`ifndef DECODER_ROW_MARKERS_EN
      else if (frame_done) check_val("done_stray", frame_done, 0);
`endif
      if (frame_done)  n_done++;
      if (error_pulse) n_err_pulse++;
      prev_stall = pixel_valid && !pixel_ready;
      prev_f = cur_f;
      if (fifo.size() == 0 && !pend && exp_q.size() == 0 && !pixel_valid) idle++;
      else idle = 0;
      if (idle >= 4) fin = 1;
    end
    if (must_finish) check_val("timeout", fin, 1);
  endtask

  task automatic finish_check();
    check_val("err_count", error_count, (m_err > 255) ? 255 : m_err);
    check_val("err_pulses", n_err_pulse, m_err);
    check_val("frames_done", n_done, m_done);
    check_val("left_beats", exp_q.size(), 0);
  endtask

  initial begin
    int used;
    int nw;
    int r;
    reset = 1'b1; queue_empty = 1'b1; queue_data = '0; pixel_ready = 1'b0;

    // clean frame, full rate
    do_reset();
    push_frame();
    nw = fifo.size();
    run_stream(2000, 100, 0, 1, used);
    check_val("throughput", used <= nw + 8, 1);
    finish_check();

    // random back-pressure, FIFO always full
    do_reset();
    repeat (3) push_frame();
    run_stream(4000, 50, 0, 1, used);
    finish_check();

    // short row then frame continues
    do_reset();
    push(c_FS);
    push_row_marker(); push_pix(W);
    push_row_marker(); push_pix(6);
    push(c_RS);        push_pix(W);
    push_row_marker(); push_pix(W);
    push_end_marker();
    run_stream(3000, 70, 10, 1, used);
    finish_check();

    // FRAME_START mid row 2 restarts the frame
    do_reset();
    push(c_FS);
    for (int i = 0; i < 2; i++) begin push_row_marker(); push_pix(W); end
    push_row_marker(); push_pix(5);
    push_frame();
    run_stream(3000, 60, 10, 1, used);
    finish_check();

    // stray pixels and unknown marker before the first frame
    do_reset();
    push_pix(2);
    push(17'h10005);
    push_frame();
    run_stream(2000, 80, 0, 1, used);
    finish_check();
    check_val("stray_err", error_count, 3);

    // error counter saturation
    do_reset();
    push_pix(300);
    run_stream(4000, 50, 0, 1, used);
    finish_check();

    // random word soup
    do_reset();
    push(c_FS);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      push_pix(1);
      else if (r < 84) push(c_FS);
      else if (r < 90) push(c_RS);
      else if (r < 95) push(c_FE);
      else             push(17'h10000 | 17'($urandom_range(2, 16'hFFFE)));
    end
    run_stream(20000, 50, 20, 1, used);
    finish_check();

    // reset while a frame is streaming
    do_reset();
    push_frame();
    run_stream(25, 100, 0, 0, used);
    do_reset();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
